// File: rtl/conv_tile_sched.sv
// Layer-level tile scheduler for a tiled convolution engine.
// Walks row -> col -> m -> n tile loops and sequences the load, conv and store
// engines with one-cycle start pulses. State, pulses and tile origins are all
// registered.
module conv_tile_sched #(
  parameter int CW = 16,
  parameter int N  = 32,
  parameter int M  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tn = 16,
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sched_start,
  output logic          in_fm_load_start,
  output logic          wt_load_start,
  input  logic          in_fm_load_done,
  input  logic          wt_load_done,
  output logic          conv_start,
  input  logic          conv_done,
  output logic          conv_first,
  output logic          conv_last,
  output logic          store_start,
  input  logic          store_done,
  output logic [CW-1:0] tile_base_n,
  output logic [CW-1:0] tile_base_m,
  output logic [CW-1:0] tile_base_row,
  output logic [CW-1:0] tile_base_col,
  output logic          busy,
  output logic          sched_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_STORE,
    S_FIN
  } state_t;

  localparam logic [CW-1:0] STEP_N = CW'(Tn);
  localparam logic [CW-1:0] STEP_M = CW'(Tm);
  localparam logic [CW-1:0] STEP_R = CW'(Tr);
  localparam logic [CW-1:0] STEP_C = CW'(Tc);
  localparam logic [CW-1:0] LAST_N = CW'(N - Tn);
  localparam logic [CW-1:0] LAST_M = CW'(M - Tm);
  localparam logic [CW-1:0] LAST_R = CW'(R - Tr);
  localparam logic [CW-1:0] LAST_C = CW'(C - Tc);

  state_t        state_q, state_d;
  logic [CW-1:0] n_q, n_d, m_q, m_d, row_q, row_d, col_q, col_d;
  logic          fm_flag_q, fm_flag_d, wt_flag_q, wt_flag_d;
  logic          fm_start_q, fm_start_d, wt_start_q, wt_start_d;
  logic          conv_start_q, conv_start_d, store_start_q, store_start_d;
  logic          first_q, first_d, last_q, last_d;
  logic          busy_q, busy_d, done_q, done_d;

  // Next-state, next-origin and registered-output decode.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    m_d           = m_q;
    row_d         = row_q;
    col_d         = col_q;
    fm_flag_d     = fm_flag_q;
    wt_flag_d     = wt_flag_q;
    fm_start_d    = 1'b0;
    wt_start_d    = 1'b0;
    conv_start_d  = 1'b0;
    store_start_d = 1'b0;
    done_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sched_start) begin
          state_d    = S_LOAD;
          fm_start_d = 1'b1;
          wt_start_d = 1'b1;
          fm_flag_d  = 1'b0;
          wt_flag_d  = 1'b0;
          n_d        = '0;
          m_d        = '0;
          row_d      = '0;
          col_d      = '0;
        end
      end
      S_LOAD: begin
        // A done arriving this cycle counts, so exit is decided on the _d flags.
        fm_flag_d = fm_flag_q | in_fm_load_done;
        wt_flag_d = wt_flag_q | wt_load_done;
        if (fm_flag_d && wt_flag_d) begin
          state_d      = S_CONV;
          conv_start_d = 1'b1;
        end
      end
      S_CONV: begin
        if (conv_done) begin
          if (n_q == LAST_N) begin
            state_d       = S_STORE;
            store_start_d = 1'b1;
          end else begin
            n_d        = n_q + STEP_N;
            state_d    = S_LOAD;
            fm_start_d = 1'b1;
            wt_start_d = 1'b1;
            fm_flag_d  = 1'b0;
            wt_flag_d  = 1'b0;
          end
        end
      end
      S_STORE: begin
        if (store_done) begin
          if (m_q == LAST_M && col_q == LAST_C && row_q == LAST_R) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            n_d = '0;
            if (m_q == LAST_M) begin
              m_d = '0;
              if (col_q == LAST_C) begin
                col_d = '0;
                row_d = row_q + STEP_R;
              end else begin
                col_d = col_q + STEP_C;
              end
            end else begin
              m_d = m_q + STEP_M;
            end
            state_d    = S_LOAD;
            fm_start_d = 1'b1;
            wt_start_d = 1'b1;
            fm_flag_d  = 1'b0;
            wt_flag_d  = 1'b0;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        n_d     = '0;
        m_d     = '0;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    first_d = (state_d == S_CONV) && (n_d == '0);
    last_d  = (state_d == S_CONV) && (n_d == LAST_N);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      m_q           <= '0;
      row_q         <= '0;
      col_q         <= '0;
      fm_flag_q     <= 1'b0;
      wt_flag_q     <= 1'b0;
      fm_start_q    <= 1'b0;
      wt_start_q    <= 1'b0;
      conv_start_q  <= 1'b0;
      store_start_q <= 1'b0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      m_q           <= m_d;
      row_q         <= row_d;
      col_q         <= col_d;
      fm_flag_q     <= fm_flag_d;
      wt_flag_q     <= wt_flag_d;
      fm_start_q    <= fm_start_d;
      wt_start_q    <= wt_start_d;
      conv_start_q  <= conv_start_d;
      store_start_q <= store_start_d;
      first_q       <= first_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign in_fm_load_start = fm_start_q;
  assign wt_load_start    = wt_start_q;
  assign conv_start       = conv_start_q;
  assign store_start      = store_start_q;
  assign conv_first       = first_q;
  assign conv_last        = last_q;
  assign tile_base_n      = n_q;
  assign tile_base_m      = m_q;
  assign tile_base_row    = row_q;
  assign tile_base_col    = col_q;
  assign busy             = busy_q;
  assign sched_done       = done_q;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Scoreboard bench for conv_tile_sched: expected pulse events are queued when a
// layer is launched, a monitor pops and compares them, and responders answer
// the start pulses with done pulses after configurable delays.
module tb_conv_tile_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_start;
  logic        in_fm_load_start, wt_load_start;
  logic        in_fm_load_done, wt_load_done;
  logic        conv_start, conv_done, conv_first, conv_last;
  logic        store_start, store_done;
  logic [15:0] tile_base_n, tile_base_m, tile_base_row, tile_base_col;
  logic        busy, sched_done;

  conv_tile_sched #(.CW(16), .N(32), .M(32), .R(64), .C(32),
                    .Tn(16), .Tm(16), .Tr(64), .Tc(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .sched_start      (sched_start),
    .in_fm_load_start (in_fm_load_start),
    .wt_load_start    (wt_load_start),
    .in_fm_load_done  (in_fm_load_done),
    .wt_load_done     (wt_load_done),
    .conv_start       (conv_start),
    .conv_done        (conv_done),
    .conv_first       (conv_first),
    .conv_last        (conv_last),
    .store_start      (store_start),
    .store_done       (store_done),
    .tile_base_n      (tile_base_n),
    .tile_base_m      (tile_base_m),
    .tile_base_row    (tile_base_row),
    .tile_base_col    (tile_base_col),
    .busy             (busy),
    .sched_done       (sched_done)
  );

  always #5 clk = ~clk;

  // kind: 0 load pair, 1 conv, 2 store, 3 layer done
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] n, m, row, col;
    logic        first, last;
  } ev_t;

  ev_t exp_q[$];
  ev_t act;
  int  rd_idx = 0;
  int  total = 0, bad = 0;
  int  cyc = 0, last_done_cyc = -10;
  int  conv_seen = 0, store_seen = 0, done_cnt = 0;
  int  mode = 0;             // 0: both +3, 1: wt +2 / fm +7, 2: both +3
  bit  inject_spur = 1'b0;
  int  fm_cnt = 0, wt_cnt = 0, cv_cnt = 0, st_cnt = 0, spur_cnt = 0;
  int  groups, c0, s0;

  task automatic chk(input string nm, input logic [79:0] a, input logic [79:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [15:0] n, m, row, col,
                         input logic f, l);
    ev_t e;
    e.kind = k; e.n = n; e.m = m; e.row = row; e.col = col; e.first = f; e.last = l;
    exp_q.push_back(e);
  endtask

  // Default geometry: one row tile, col in {0,16}, m in {0,16}, n in {0,16}.
  task automatic push_layer();
    for (int unsigned c = 0; c < 2; c++) begin
      for (int unsigned mm = 0; mm < 2; mm++) begin
        push_ev(2'd0, 16'd0,  16'(mm * 16), 16'd0, 16'(c * 16), 1'b0, 1'b0);
        push_ev(2'd1, 16'd0,  16'(mm * 16), 16'd0, 16'(c * 16), 1'b1, 1'b0);
        push_ev(2'd0, 16'd16, 16'(mm * 16), 16'd0, 16'(c * 16), 1'b0, 1'b0);
        push_ev(2'd1, 16'd16, 16'(mm * 16), 16'd0, 16'(c * 16), 1'b0, 1'b1);
        push_ev(2'd2, 16'd16, 16'(mm * 16), 16'd0, 16'(c * 16), 1'b0, 1'b0);
      end
    end
    push_ev(2'd3, 16'd16, 16'd16, 16'd0, 16'd16, 1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk); sched_start = 1'b1;
    @(negedge clk); sched_start = 1'b0;
  endtask

  task automatic wait_layer(input int target, input string nm);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(nm, 80'(done_cnt), 80'(target));
  endtask

  function automatic logic [79:0] all_outs();
    return {in_fm_load_start, wt_load_start, conv_start, conv_first, conv_last,
            store_start, busy, sched_done,
            tile_base_n, tile_base_m, tile_base_row, tile_base_col};
  endfunction

  initial begin
    rst = 1'b1; sched_start = 1'b0;
    in_fm_load_done = 1'b0; wt_load_done = 1'b0; conv_done = 1'b0; store_done = 1'b0;
    fork
      forever @(posedge clk) cyc++;
      // monitor
      forever @(negedge clk) begin
        if (rst) begin
          rd_idx = exp_q.size();
        end else if (in_fm_load_start | wt_load_start | conv_start | store_start | sched_done) begin
          groups = int'(in_fm_load_start | wt_load_start) + int'(conv_start)
                 + int'(store_start) + int'(sched_done);
          chk("one_group", 80'(groups), 80'd1);
          chk("busy_with_pulse", 80'(busy), 80'd1);
          if (in_fm_load_start | wt_load_start)
            chk("load_pair", 80'(in_fm_load_start), 80'(wt_load_start));
          act.kind  = sched_done ? 2'd3 : store_start ? 2'd2 : conv_start ? 2'd1 : 2'd0;
          act.n     = tile_base_n;
          act.m     = tile_base_m;
          act.row   = tile_base_row;
          act.col   = tile_base_col;
          act.first = conv_first;
          act.last  = conv_last;
          chk("exp_available", 80'(rd_idx < exp_q.size()), 80'd1);
          if (rd_idx < exp_q.size()) begin
            chk("event", 80'(act), 80'(exp_q[rd_idx]));
            rd_idx++;
          end
          if (conv_start) begin
            chk("conv_latency", 80'(cyc), 80'(last_done_cyc + 1));
            conv_seen++;
          end
          if (store_start) store_seen++;
          if (sched_done)  done_cnt++;
        end
      end
      // responders
      forever @(negedge clk) begin
        in_fm_load_done = 1'b0; wt_load_done = 1'b0; conv_done = 1'b0; store_done = 1'b0;
        if (rst) begin
          fm_cnt = 0; wt_cnt = 0; cv_cnt = 0; st_cnt = 0; spur_cnt = 0;
        end else begin
          if (fm_cnt > 0) begin
            fm_cnt--;
            if (fm_cnt == 0) begin in_fm_load_done = 1'b1; last_done_cyc = cyc; end
          end
          if (wt_cnt > 0) begin
            wt_cnt--;
            if (wt_cnt == 0) begin wt_load_done = 1'b1; last_done_cyc = cyc; end
          end
          if (cv_cnt > 0) begin cv_cnt--; if (cv_cnt == 0) conv_done = 1'b1; end
          if (st_cnt > 0) begin st_cnt--; if (st_cnt == 0) store_done = 1'b1; end
          if (spur_cnt > 0) begin spur_cnt--; if (spur_cnt == 0) store_done = 1'b1; end
          if (in_fm_load_start) begin
            fm_cnt = (mode == 1) ? 7 : 3;
            wt_cnt = (mode == 1) ? 2 : 3;
            if (inject_spur) begin spur_cnt = 1; inject_spur = 1'b0; end
          end
          if (conv_start)  cv_cnt = 3;
          if (store_start) st_cnt = 3;
        end
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 80'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 80'(busy), 80'd0);

    // layer 1: plain 3-cycle responders
    mode = 0;
    push_layer();
    pulse_start();
    wait_layer(1, "layer1_done");
    chk("idle_after_layer", all_outs(), 80'd0);

    // layer 2: wt done 5 cycles before fm done, spurious store_done in LOAD,
    // sched_start pulsed during CONV
    mode = 1;
    inject_spur = 1'b1;
    push_layer();
    pulse_start();
    c0 = conv_seen;
    for (int i = 0; i < 200 && conv_seen == c0; i++) @(negedge clk);
    chk("conv_seen_l2", 80'(conv_seen > c0), 80'd1);
    @(negedge clk); sched_start = 1'b1;
    @(negedge clk); sched_start = 1'b0;
    wait_layer(2, "layer2_done");

    // layer 3: both load dones in the same cycle
    mode = 2;
    push_layer();
    pulse_start();
    wait_layer(3, "layer3_done");

    // layer 4: reset during the second STORE, then a fresh layer
    mode = 0;
    push_layer();
    s0 = store_seen;
    pulse_start();
    for (int i = 0; i < 500 && store_seen < s0 + 2; i++) @(negedge clk);
    chk("second_store_seen", 80'(store_seen), 80'(s0 + 2));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_layer_reset_outs", all_outs(), 80'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_reset_idle", all_outs(), 80'd0);
    chk("no_done_after_reset", 80'(done_cnt), 80'd3);
    push_layer();
    pulse_start();
    wait_layer(4, "layer5_done");

    chk("queue_drained", 80'(rd_idx), 80'(exp_q.size()));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
